card_dealer: RTL and testbench

CARD_DEALER -- requirements
Module: card_dealer

---
 rtl/card_dealer_if.sv | 7 +
 rtl/card_dealer.sv | 122 ++++++++++++
 tb/tb_card_dealer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/card_dealer_if.sv
// rtl/card_dealer_if.sv - SM_if: the nine player hand slots published by card_dealer
interface SM_if;
  logic [3:0] player_card_values [0:8];

  modport out (output player_card_values);
  modport in  (input  player_card_values);
endinterface

// File: rtl/card_dealer.sv
// rtl/card_dealer.sv - LFSR-driven card dealer into a 9-slot hand.
// Optional per-rank shoe tracking is enabled with `define DEALER_SHOE_TRACK_EN.
module card_dealer #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       deal_req,
  input  logic       new_round,
  input  logic       shuffle,
  output logic       deal_ack,
  output logic       deal_err,
  output logic [3:0] card_count,
  output logic       hand_full,
  SM_if.out          card_if
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_DRAW = 1'b1;

  logic [15:0] lfsr_q, lfsr_d;
  logic [0:0]  state_q, state_d;
  logic [3:0]  card_count_q, card_count_d;
  logic [3:0]  slot_q [0:8];
  logic [3:0]  slot_d [0:8];
  logic        ack_q, err_q;

  logic [3:0]  cand;
  logic        cand_in_range;
  logic        rank_avail;
  logic        shoe_empty;
  logic        accept;
  logic        start;
  logic        refuse;

  assign cand       = lfsr_q[3:0];
  assign hand_full  = (card_count_q == 4'd9);
  assign card_count = card_count_q;
  assign deal_ack   = ack_q;
  assign deal_err   = err_q;

  for (genvar g = 0; g < 9; g++) begin : g_slot_out
    assign card_if.player_card_values[g] = slot_q[g];
  end

`ifdef DEALER_SHOE_TRACK_EN
  logic [2:0] shoe_q [1:13];
  logic [2:0] shoe_d [1:13];

  // Shuffle refill wins over a same-cycle decrement.
  always_comb begin
    rank_avail = 1'b0;
    shoe_empty = 1'b1;
    for (int r = 1; r <= 13; r++) begin
      shoe_d[r] = shoe_q[r];
      if (shoe_q[r] != 3'd0) shoe_empty = 1'b0;
      if ((cand == 4'(r)) && (shoe_q[r] != 3'd0)) rank_avail = 1'b1;
      if (shuffle) begin
        shoe_d[r] = 3'd4;
      end else if (accept && (cand == 4'(r))) begin
        shoe_d[r] = shoe_q[r] - 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 1; r <= 13; r++) shoe_q[r] <= 3'd4;
    end else begin
      for (int r = 1; r <= 13; r++) shoe_q[r] <= shoe_d[r];
    end
  end
`else
  logic unused_shuffle;
  assign unused_shuffle = shuffle;
  assign rank_avail     = 1'b1;
  assign shoe_empty     = 1'b0;
`endif

  // new_round overrides every other action in its cycle.
  always_comb begin
    lfsr_d        = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    cand_in_range = (cand >= 4'd1) && (cand <= 4'd13);
    accept        = (state_q == S_DRAW) && cand_in_range && rank_avail && !new_round;
    start         = (state_q == S_IDLE) && deal_req && !hand_full && !shoe_empty && !new_round;
    refuse        = (state_q == S_IDLE) && deal_req && (hand_full || shoe_empty) && !new_round;

    state_d = state_q;
    if (new_round)   state_d = S_IDLE;
    else if (start)  state_d = S_DRAW;
    else if (accept) state_d = S_IDLE;

    card_count_d = card_count_q;
    if (new_round)   card_count_d = 4'd0;
    else if (accept) card_count_d = card_count_q + 4'd1;

    for (int i = 0; i < 9; i++) begin
      slot_d[i] = slot_q[i];
      if (new_round) slot_d[i] = 4'd0;
      else if (accept && (card_count_q == 4'(i))) slot_d[i] = cand;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q       <= SEED;
      state_q      <= S_IDLE;
      card_count_q <= 4'd0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      for (int i = 0; i < 9; i++) slot_q[i] <= 4'd0;
    end else begin
      lfsr_q       <= lfsr_d;
      state_q      <= state_d;
      card_count_q <= card_count_d;
      ack_q        <= accept;
      err_q        <= refuse;
      for (int i = 0; i < 9; i++) slot_q[i] <= slot_d[i];
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
// tb/tb_card_dealer.sv - scoreboard bench for card_dealer with a behavioural dealing model
module tb_card_dealer;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst, deal_req, new_round, shuffle;
  logic       deal_ack, deal_err, hand_full;
  logic [3:0] card_count;

  SM_if card_if();

  card_dealer #(.SEED(SEED)) dut (
    .clk(clk), .rst(rst), .deal_req(deal_req), .new_round(new_round), .shuffle(shuffle),
    .deal_ack(deal_ack), .deal_err(deal_err), .card_count(card_count),
    .hand_full(hand_full), .card_if(card_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_err = 0;
  logic [15:0] m_lfsr;

  typedef struct {
    bit is_err;
    int card;
    int count;
    int at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int m_hand[9];
  int m_count;
  int m_shoe[14];
  int first_card;

  function automatic logic [15:0] step(input logic [15:0] v);
    logic [15:0] fb;
    fb = ((v >> 0) ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 16'd1;
    return (v >> 1) | (fb << 15);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= step(m_lfsr);
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (deal_ack && deal_err) chk("ack_err_exclusive", 1, 0);
      if (deal_err) n_err++;
      if (deal_ack || deal_err) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", int'(deal_ack) * 2 + int'(deal_err), 0);
        end else begin
          mon_e = sb.pop_front();
          chk("pulse_is_err", int'(deal_err), int'(mon_e.is_err));
          chk("pulse_cycle", cyc, mon_e.at);
          if (!mon_e.is_err) begin
            chk("dealt_card", int'(card_if.player_card_values[mon_e.count-1]), mon_e.card);
            chk("count_after_deal", int'(card_count), mon_e.count);
          end
        end
      end
    end
  end

  task automatic m_reset();
    for (int i = 0; i < 9; i++) m_hand[i] = 0;
    m_count = 0;
    for (int r = 0; r < 14; r++) m_shoe[r] = 4;
  endtask

  function automatic bit cand_ok(input int c);
`ifdef DEALER_SHOE_TRACK_EN
    return (c >= 1) && (c <= 13) && (m_shoe[c] > 0);
`else
    return (c >= 1) && (c <= 13);
`endif
  endfunction

  function automatic bit shoe_empty();
`ifdef DEALER_SHOE_TRACK_EN
    int s = 0;
    for (int r = 1; r <= 13; r++) s += m_shoe[r];
    return s == 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_hand(input string tag);
    for (int i = 0; i < 9; i++)
      chk({tag, "_slot"}, int'(card_if.player_card_values[i]), m_hand[i]);
    chk({tag, "_count"}, int'(card_count), m_count);
    chk({tag, "_full"}, int'(hand_full), int'(m_count == 9));
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("deal_response_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  // Number of LFSR steps until the first acceptable candidate, from the current model state.
  function automatic int steps_to_accept(output int card);
    logic [15:0] l = m_lfsr;
    int i = 0;
    do begin
      l = step(l);
      i++;
    end while (!cand_ok(int'(l[3:0])) && i < 100000);
    card = int'(l[3:0]);
    return i;
  endfunction

  task automatic deal();
    exp_t e;
    int c, i;
    if (m_count == 9 || shoe_empty()) begin
      e.is_err = 1'b1; e.card = 0; e.count = m_count; e.at = cyc + 1;
    end else begin
      i = steps_to_accept(c);
      e.is_err = 1'b0; e.card = c;
      m_hand[m_count] = c;
      m_count++;
      e.count = m_count; e.at = cyc + 1 + i;
`ifdef DEALER_SHOE_TRACK_EN
      m_shoe[c]--;
`endif
    end
    sb.push_back(e);
    deal_req = 1'b1;
    @(negedge clk);
    deal_req = 1'b0;
    wait_done();
  endtask

  task automatic do_new_round();
    new_round = 1'b1;
    @(negedge clk);
    new_round = 1'b0;
    for (int i = 0; i < 9; i++) m_hand[i] = 0;
    m_count = 0;
  endtask

  task automatic do_shuffle();
    shuffle = 1'b1;
    @(negedge clk);
    shuffle = 1'b0;
    for (int r = 0; r < 14; r++) m_shoe[r] = 4;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, i, errs0;
    int tally[14];
    rst = 1'b1; deal_req = 1'b0; new_round = 1'b0; shuffle = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    check_hand("reset");
    chk("reset_ack", int'(deal_ack), 0);
    chk("reset_err", int'(deal_err), 0);
    rst = 1'b0;

    deal();
    first_card = m_hand[0];
    repeat (8) deal();
    check_hand("nine_deals");
    chk("nine_full", int'(hand_full), 1);
    errs0 = n_err;
    deal();
    chk("tenth_err", n_err - errs0, 1);
    check_hand("after_refuse");

    do_new_round();
    repeat (5) deal();
    check_hand("five_cards");
    do_new_round();
    check_hand("new_round_clear");

    repeat (2) deal();
    i = steps_to_accept(c);
    deal_req = 1'b1;
    @(negedge clk);
    deal_req = 1'b0;
    repeat (i - 1) @(negedge clk);
    do_new_round();
    check_hand("abort_accept");
    repeat (4) @(negedge clk);
    deal();
    check_hand("deal_after_abort");

    repeat (3) deal();
    deal_req = 1'b1;
    @(negedge clk);
    deal_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    m_reset();
    sb.delete();
    check_hand("async_reset");
    chk("async_reset_ack", int'(deal_ack), 0);
    chk("async_reset_err", int'(deal_err), 0);
    @(negedge clk);
    rst = 1'b0;
    deal();
    chk("first_card_after_reset", int'(card_if.player_card_values[0]), first_card);

`ifdef DEALER_SHOE_TRACK_EN
    do_new_round();
    for (int r = 0; r < 14; r++) tally[r] = 0;
    tally[first_card]++;
    for (int k = 1; k < 52; k++) begin
      if (m_count == 9) do_new_round();
      deal();
      tally[card_if.player_card_values[card_count - 1]]++;
    end
    for (int r = 1; r <= 13; r++) chk("rank_tally", tally[r], 4);
    do_new_round();
    errs0 = n_err;
    deal();
    chk("shoe_empty_err", n_err - errs0, 1);
    do_shuffle();
    deal();
    check_hand("after_shuffle");
`else
    for (int r = 0; r < 14; r++) tally[r] = 0;
`endif

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    errs0 = n_err;
    for (int k = 0; k < 60; k++) begin
      if (m_count == 9) do_new_round();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 4) == 0) do_shuffle();
      deal();
    end
    check_hand("random_end");
`ifndef DEALER_SHOE_TRACK_EN
    chk("random_no_err", n_err - errs0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
